// File: rtl/bip_pkg.sv
// Shared types and defaults for the BIP1 run controller.
// Holds the FSM state encoding, opcode constants and byte indices.
package bip_pkg;

  localparam int NB_INSTRUC_D = 16;
  localparam int NB_OPCODE_D  = 5;
  localparam int NB_ADDR_D    = 11;
  localparam int NB_BYTE_D    = 8;
  localparam int NB_CYC_D     = 32;

  localparam logic [31:0] MAX_CYCLES_D = 32'h000F_FFFF;
  localparam logic [4:0]  HALT_OPC_D   = 5'b00000;

  localparam logic [1:0] BYTE_FIRST = 2'd0;
  localparam logic [1:0] BYTE_LAST  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LOAD_HI,
    S_LOAD_LO,
    S_RUN,
    S_TX_SEND,
    S_TX_WAIT
  } state_t;

endpackage

// File: rtl/bip_cycle_counter.sv
// Saturating run-cycle counter with a watchdog limit flag.
// Clear wins over enable; freeze holds the value.
module bip_cycle_counter
  import bip_pkg::*;
#(
  parameter int                NB_CYC     = NB_CYC_D,
  parameter logic [NB_CYC-1:0] MAX_CYCLES = NB_CYC'(MAX_CYCLES_D)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic              i_freeze,
  output logic [NB_CYC-1:0] o_count,
  output logic              o_limit
);

  logic [NB_CYC-1:0] r_count;
  logic              w_sat;

  assign w_sat = &r_count;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !i_freeze && !w_sat) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_limit = (r_count >= MAX_CYCLES);

endmodule

// File: rtl/bip_run_ctrl.sv
// Loads BIP1 program memory from a byte stream, runs the CPU,
// then returns the 32-bit cycle count MSB first.
module bip_run_ctrl
  import bip_pkg::*;
#(
  parameter int                    NB_INSTRUC  = NB_INSTRUC_D,
  parameter int                    NB_OPCODE   = NB_OPCODE_D,
  parameter int                    NB_ADDR     = NB_ADDR_D,
  parameter int                    NB_BYTE     = NB_BYTE_D,
  parameter int                    NB_CYC      = NB_CYC_D,
  parameter logic [NB_CYC-1:0]     MAX_CYCLES  = NB_CYC'(MAX_CYCLES_D),
  parameter logic [NB_OPCODE-1:0]  HALT_OPCODE = NB_OPCODE'(HALT_OPC_D)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NB_BYTE-1:0]    i_rx_data,
  input  logic                  i_rx_valid,
  input  logic [NB_INSTRUC-1:0] i_instruc,
  input  logic                  i_tx_done,
  output logic [NB_ADDR-1:0]    o_pm_addr,
  output logic [NB_INSTRUC-1:0] o_pm_data,
  output logic                  o_pm_we,
  output logic                  o_cpu_rst,
  output logic [NB_BYTE-1:0]    o_tx_data,
  output logic                  o_tx_start,
  output logic                  o_busy,
  output logic                  o_timeout
);

  localparam int NB_LEN = 2 * NB_BYTE;

  state_t                r_state;
  state_t                w_next;
  logic [NB_BYTE-1:0]    r_len_hi;
  logic [NB_LEN-1:0]     r_left;
  logic [NB_ADDR-1:0]    r_addr;
  logic [NB_INSTRUC-1:0] r_data;
  logic                  r_we;
  logic                  r_timeout;
  logic [1:0]            r_k;

  logic [NB_LEN-1:0]     w_len;
  logic                  w_halt;
  logic                  w_limit;
  logic                  w_stop;
  logic                  w_load_end;
  logic                  w_clr;
  logic                  w_en;
  logic [NB_CYC-1:0]     w_count;

  assign w_len  = {r_len_hi, i_rx_data};
  assign w_halt = (i_instruc[NB_INSTRUC-1 -: NB_OPCODE]
                   == HALT_OPCODE);

  // Last word's write pulse occupies LOAD_LO with nothing left.
  assign w_load_end = (r_state == S_LOAD_LO) && (r_left == '0);
  assign w_stop     = (r_state == S_RUN) && (w_halt || w_limit);
  assign w_clr      = (r_state == S_LEN_LO) && i_rx_valid;
  assign w_en       = w_load_end || (r_state == S_RUN);

  bip_cycle_counter #(
    .NB_CYC     (NB_CYC),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_cnt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (w_en),
    .i_clr    (w_clr),
    .i_freeze (w_stop),
    .o_count  (w_count),
    .o_limit  (w_limit)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (i_rx_valid) w_next = S_LEN_LO;
      S_LEN_LO:
        if (i_rx_valid)
          w_next = (w_len == '0) ? S_IDLE : S_LOAD_HI;
      S_LOAD_HI:
        if (i_rx_valid) w_next = S_LOAD_LO;
      S_LOAD_LO:
        if (r_left == '0)
          w_next = S_RUN;
        else if (i_rx_valid)
          w_next = (r_left == NB_LEN'(1)) ? S_LOAD_LO
                                          : S_LOAD_HI;
      S_RUN:
        if (w_stop) w_next = S_TX_SEND;
      S_TX_SEND:
        w_next = S_TX_WAIT;
      S_TX_WAIT:
        if (i_tx_done)
          w_next = (r_k == BYTE_LAST) ? S_IDLE : S_TX_SEND;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= S_IDLE;
      r_len_hi  <= '0;
      r_left    <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_we      <= 1'b0;
      r_timeout <= 1'b0;
      r_k       <= BYTE_FIRST;
    end else begin
      r_state <= w_next;
      r_we    <= 1'b0;
      if (r_we) r_addr <= r_addr + 1'b1;
      if (r_state == S_IDLE && i_rx_valid)
        r_len_hi <= i_rx_data;
      if (r_state == S_LEN_LO && i_rx_valid) begin
        r_left <= w_len;
        r_addr <= '0;
      end
      if (r_state == S_LOAD_HI && i_rx_valid)
        r_data[NB_INSTRUC-1 -: NB_BYTE] <= i_rx_data;
      if (r_state == S_LOAD_LO && i_rx_valid
          && r_left != '0) begin
        r_data[NB_BYTE-1:0] <= i_rx_data;
        r_we                <= 1'b1;
        r_left              <= r_left - 1'b1;
      end
      if (w_load_end) begin
        r_timeout <= 1'b0;
        r_k       <= BYTE_FIRST;
      end else if (w_stop) begin
        r_timeout <= !w_halt;
      end
      if (r_state == S_TX_WAIT && i_tx_done)
        r_k <= r_k + 1'b1;
    end
  end

  assign o_pm_addr  = r_addr;
  assign o_pm_data  = r_data;
  assign o_pm_we    = r_we;
  assign o_cpu_rst  = (r_state != S_RUN);
  assign o_tx_start = (r_state == S_TX_SEND);
  assign o_busy     = (r_state != S_IDLE);
  assign o_timeout  = r_timeout;
  assign o_tx_data  = NB_BYTE'(w_count >>
                      (NB_BYTE * 32'(BYTE_LAST - r_k)));

endmodule

// File: tb/tb_bip_run_ctrl.sv
// Directed bench for bip_run_ctrl: load, run, halt,
// watchdog, address wrap and reset abort.
module tb_bip_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [15:0] instruc;
  logic        tx_done = 1'b0;
  logic [1:0]  pm_addr;
  logic [15:0] pm_data;
  logic        pm_we;
  logic        cpu_rst;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        busy;
  logic        timeout;

  int n_chk = 0;
  int n_err = 0;
  int halt_at = 0;
  int run_cyc = 0;
  logic run_clr = 1'b0;
  logic [1:0]  wa[$];
  logic [15:0] wd[$];
  int wbase;

  bip_run_ctrl #(
    .NB_ADDR    (2),
    .MAX_CYCLES (32'd16)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .i_instruc  (instruc),
    .i_tx_done  (tx_done),
    .o_pm_addr  (pm_addr),
    .o_pm_data  (pm_data),
    .o_pm_we    (pm_we),
    .o_cpu_rst  (cpu_rst),
    .o_tx_data  (tx_data),
    .o_tx_start (tx_start),
    .o_busy     (busy),
    .o_timeout  (timeout)
  );

  always #5 clk = ~clk;

  always_comb begin
    instruc = 16'h0800;
    if (halt_at != 0 && run_cyc + 1 >= halt_at)
      instruc = 16'h07FF;
  end

  always @(posedge clk) begin
    if (run_clr) run_cyc <= 0;
    else if (!cpu_rst) run_cyc <= run_cyc + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && pm_we) begin
      wa.push_back(pm_addr);
      wd.push_back(pm_data);
      chk("we_excl", {30'd0, tx_start, cpu_rst}, 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic start(input int h);
    halt_at = h;
    run_clr = 1'b1;
    tick();
    run_clr = 1'b0;
    wbase = wa.size();
  endtask

  task automatic wait_tx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic tx_collect(input logic [31:0] exp,
                            input bit early,
                            input bit inject);
    bit ok;
    logic [7:0] eb;
    for (int b = 0; b < 4; b++) begin
      eb = exp[31 - 8*b -: 8];
      wait_tx(ok);
      if (!ok) begin
        chk("tx_start_to", 0, 1);
        return;
      end
      chk($sformatf("tx_byte%0d", b), tx_data, eb);
      if (early && b == 0) tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      if (inject) begin
        rx_data  = 8'h00;
        rx_valid = 1'b1;
      end
      repeat (3) tick();
      rx_valid = 1'b0;
      chk($sformatf("tx_hold%0d", b),
          {23'd0, tx_start, tx_data}, {24'd0, eb});
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
    chk("tx_idle", busy, 0);
  endtask

  task automatic chk_w(input int i,
                       input logic [1:0] a,
                       input logic [15:0] d);
    if (wa.size() > wbase + i) begin
      chk($sformatf("w%0d_addr", i), wa[wbase+i], a);
      chk($sformatf("w%0d_data", i), wd[wbase+i], d);
    end else begin
      chk($sformatf("w%0d_missing", i), 0, 1);
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_outs",
        {busy, timeout, pm_we, tx_start, cpu_rst},
        5'b00001);
    rst_n = 1'b1;
    tick();

    // reset aborts a load in progress
    start(0);
    send(8'h00);
    send(8'h02);
    send(8'hA8);
    rst_n = 1'b0;
    #2;
    chk("midrst_flags",
        {busy, timeout, pm_we, tx_start, cpu_rst},
        5'b00001);
    chk("midrst_data", {pm_addr, pm_data, tx_data}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("midrst_nowe", wa.size() - wbase, 0);
    chk("midrst_busy", busy, 0);

    // two words, HALT on second run cycle
    start(2);
    send(8'h00);
    send(8'h02);
    send(8'hA8);
    send(8'h01);
    send(8'h00);
    send(8'h00);
    tx_collect(32'd2, 1'b0, 1'b0);
    chk("n2_nw", wa.size() - wbase, 2);
    chk_w(0, 2'd0, 16'hA801);
    chk_w(1, 2'd1, 16'h0000);
    chk("n2_runcyc", run_cyc, 2);
    chk("n2_tmo", timeout, 0);

    // empty program
    start(0);
    send(8'h00);
    chk("n0_busy1", busy, 1);
    send(8'h00);
    chk("n0_state", {busy, cpu_rst}, 2'b01);
    repeat (3) tick();
    chk("n0_nowe", wa.size() - wbase, 0);
    chk("n0_norun", run_cyc, 0);

    // watchdog
    start(0);
    send(8'h00);
    send(8'h01);
    send(8'h08);
    send(8'h00);
    tx_collect(32'd16, 1'b0, 1'b0);
    chk("wd_runcyc", run_cyc, 16);
    chk("wd_tmo", timeout, 1);

    // address wrap, HALT first cycle, rx ignored, early done
    start(1);
    send(8'h00);
    send(8'h05);
    for (int i = 1; i <= 4; i++) begin
      send(8'(i * 8'h11));
      send(8'(i * 8'h11));
    end
    send(8'h55);
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    tick();
    rx_data = 8'h00;
    repeat (2) tick();
    rx_valid = 1'b0;
    chk("wr_tmo_clr", timeout, 0);
    tx_collect(32'd1, 1'b1, 1'b1);
    chk("wr_nw", wa.size() - wbase, 5);
    chk_w(0, 2'd0, 16'h1111);
    chk_w(1, 2'd1, 16'h2222);
    chk_w(2, 2'd2, 16'h3333);
    chk_w(3, 2'd3, 16'h4444);
    chk_w(4, 2'd0, 16'h5555);
    chk("wr_runcyc", run_cyc, 1);
    chk("wr_tmo", timeout, 0);
    repeat (3) tick();
    chk("wr_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
